// File: rtl/pipe_ctrl.sv
// Front-end pipeline scheduler: merges hold requests into one hold level, picks a
// redirect target, bubbles IF/ID through a flush window and times out stuck bus holds.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned BUS_TIMEOUT  = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_jump_req_i,
   input  logic [31:0] ex_jump_addr_i,
   input  logic        ex_hold_req_i,
   input  logic        clint_hold_req_i,
   input  logic        clint_int_req_i,
   input  logic [31:0] clint_int_addr_i,
   input  logic        bus_hold_req_i,
   output logic [2:0]  hold_flag_o,
   output logic        jump_flag_o,
   output logic [31:0] jump_addr_o,
   output logic        bus_timeout_o,
   output logic        flush_state_o
);

   localparam logic [2:0] HOLD_NONE = 3'd0;
   localparam logic [2:0] HOLD_PC   = 3'd1;
   localparam logic [2:0] HOLD_ID   = 3'd3;

   localparam int unsigned BCW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
   localparam logic [3:0]     FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [BCW-1:0] BUS_LAST   = BCW'(BUS_TIMEOUT - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t         state;
   logic [3:0]     flush_cnt;
   logic [BCW-1:0] bus_cnt;
   logic           bus_masked;

   logic           redirect;
   logic [31:0]    redirect_addr;
   logic           bus_active;
   logic           bus_expire;

   // Interrupt outranks a same-cycle jump; the jump is dropped because EX is flushed.
   always_comb begin
      redirect      = 1'b0;
      redirect_addr = 32'd0;
      if (!rst_i) begin
         if (clint_int_req_i) begin
            redirect      = 1'b1;
            redirect_addr = clint_int_addr_i & 32'hFFFF_FFFC;
         end else if (ex_jump_req_i) begin
            redirect      = 1'b1;
            redirect_addr = ex_jump_addr_i & 32'hFFFF_FFFC;
         end
      end
   end

   assign bus_active = bus_hold_req_i && !bus_masked;
   assign bus_expire = bus_active && (bus_cnt == BUS_LAST);

   // Redirect flush window: FLUSH lasts FLUSH_CYCLES cycles after the last redirect.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         flush_cnt <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (redirect) begin
                  state     <= S_FLUSH;
                  flush_cnt <= FLUSH_LOAD;
               end
            end
            S_FLUSH: begin
               if (redirect) begin
                  flush_cnt <= FLUSH_LOAD;
               end else if (flush_cnt == 4'd0) begin
                  state <= S_IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            default: begin
               state     <= S_IDLE;
               flush_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Bus watchdog: the counter parks at its last value once the mask is set.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus_cnt    <= '0;
         bus_masked <= 1'b0;
      end else if (!bus_hold_req_i) begin
         bus_cnt    <= '0;
         bus_masked <= 1'b0;
      end else if (bus_active) begin
         if (bus_expire) begin
            bus_masked <= 1'b1;
         end else begin
            bus_cnt <= bus_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      hold_flag_o = HOLD_NONE;
      if (!rst_i) begin
         if (redirect || (state == S_FLUSH) || clint_hold_req_i) begin
            hold_flag_o = HOLD_ID;
         end else if (ex_hold_req_i || bus_active) begin
            hold_flag_o = HOLD_PC;
         end
      end
   end

   assign jump_flag_o   = redirect;
   assign jump_addr_o   = redirect_addr;
   assign bus_timeout_o = bus_expire && !rst_i;
   assign flush_state_o = (state == S_FLUSH);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a flush-window / bus-streak model.
module tb_pipe_ctrl;

   localparam int F  = 2;
   localparam int BT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        jmp;
   logic [31:0] jmp_addr;
   logic        ex_hold;
   logic        clint_hold;
   logic        irq;
   logic [31:0] irq_addr;
   logic        bus_req;
   logic [2:0]  hold_flag;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        bus_timeout;
   logic        flush_state;

   int checks = 0;
   int errors = 0;

   // model state: cycles of flush still owed, and index of this cycle in the bus streak
   int flush_left = 0;
   int bus_run    = 0;

   pipe_ctrl #(.FLUSH_CYCLES(F), .BUS_TIMEOUT(BT)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .ex_jump_req_i    (jmp),
      .ex_jump_addr_i   (jmp_addr),
      .ex_hold_req_i    (ex_hold),
      .clint_hold_req_i (clint_hold),
      .clint_int_req_i  (irq),
      .clint_int_addr_i (irq_addr),
      .bus_hold_req_i   (bus_req),
      .hold_flag_o      (hold_flag),
      .jump_flag_o      (jump_flag),
      .jump_addr_o      (jump_addr),
      .bus_timeout_o    (bus_timeout),
      .flush_state_o    (flush_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle compare against the model, then advance the model by one clock
   always @(negedge clk) begin
      logic        e_redir;
      logic [31:0] e_addr;
      logic [2:0]  e_hold;
      logic        e_to;
      e_redir = !rst && (irq || jmp);
      e_addr  = !e_redir ? 32'd0 : (irq ? {irq_addr[31:2], 2'b00} : {jmp_addr[31:2], 2'b00});
      if (rst) e_hold = 3'd0;
      else if (e_redir || flush_left > 0 || clint_hold) e_hold = 3'd3;
      else if (ex_hold || (bus_req && bus_run < BT)) e_hold = 3'd1;
      else e_hold = 3'd0;
      e_to = !rst && bus_req && (bus_run == BT - 1);
      chk("m_jump_flag", 32'(jump_flag), 32'(e_redir));
      chk("m_jump_addr", jump_addr, e_addr);
      chk("m_hold", 32'(hold_flag), 32'(e_hold));
      chk("m_timeout", 32'(bus_timeout), 32'(e_to));
      chk("m_flush_state", 32'(flush_state), 32'(flush_left > 0));
      if (rst) begin
         flush_left = 0;
         bus_run    = 0;
      end else begin
         if (e_redir) flush_left = F;
         else if (flush_left > 0) flush_left--;
         bus_run = bus_req ? ((bus_run < 1000) ? bus_run + 1 : bus_run) : 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      jmp = 0; jmp_addr = 0; ex_hold = 0; clint_hold = 0;
      irq = 0; irq_addr = 0; bus_req = 0;
   endtask

   initial begin
      int streak;
      rst = 1;
      idle_inputs();

      // T1: reset with random inputs
      for (int i = 0; i < 2; i++) begin
         jmp = 1'($urandom); jmp_addr = $urandom; ex_hold = 1'($urandom);
         clint_hold = 1'($urandom); irq = 1'($urandom); irq_addr = $urandom;
         bus_req = 1'($urandom);
         cyc();
      end
      rst = 0;
      idle_inputs();
      #3;
      chk("t1_hold", 32'(hold_flag), 32'd0);
      chk("t1_jump_flag", 32'(jump_flag), 32'd0);
      chk("t1_timeout", 32'(bus_timeout), 32'd0);
      cyc();

      // T2: single jump, misaligned target
      jmp = 1; jmp_addr = 32'h0000_1003;
      #3;
      chk("t2_flag", 32'(jump_flag), 32'd1);
      chk("t2_addr", jump_addr, 32'h0000_1000);
      chk("t2_hold0", 32'(hold_flag), 32'd3);
      cyc(); jmp = 0; jmp_addr = 0;
      #3 chk("t2_hold1", 32'(hold_flag), 32'd3);
      cyc();
      #3 chk("t2_hold2", 32'(hold_flag), 32'd3);
      cyc();
      #3 chk("t2_hold3", 32'(hold_flag), 32'd0);
      cyc();

      // T3: interrupt beats jump, then a jump reloads the window
      irq = 1; irq_addr = 32'h0000_0080; jmp = 1; jmp_addr = 32'h0000_2000;
      #3;
      chk("t3_addr_int", jump_addr, 32'h0000_0080);
      chk("t3_flag", 32'(jump_flag), 32'd1);
      cyc(); irq = 0; irq_addr = 0;
      #3 chk("t3_addr_jmp", jump_addr, 32'h0000_2000);
      cyc(); jmp = 0; jmp_addr = 0;
      #3 chk("t3_hold_a", 32'(hold_flag), 32'd3);
      cyc();
      #3 chk("t3_hold_b", 32'(hold_flag), 32'd3);
      cyc();
      #3 chk("t3_hold_c", 32'(hold_flag), 32'd0);
      cyc();

      // T4: EX stall with a CLINT hold overlapping from its third cycle
      for (int i = 1; i <= 5; i++) begin
         ex_hold = 1;
         clint_hold = (i >= 3);
         #3 chk("t4_hold", 32'(hold_flag), (i >= 3) ? 32'd3 : 32'd1);
         cyc();
      end
      idle_inputs();
      #3 chk("t4_hold_end", 32'(hold_flag), 32'd0);
      cyc();

      // T5: bus watchdog
      for (int i = 0; i < 20; i++) begin
         bus_req = 1;
         #3;
         chk("t5_hold", 32'(hold_flag), (i <= 7) ? 32'd1 : 32'd0);
         chk("t5_timeout", 32'(bus_timeout), (i == 7) ? 32'd1 : 32'd0);
         cyc();
      end
      bus_req = 0;
      #3 chk("t5_drop", 32'(hold_flag), 32'd0);
      cyc();
      bus_req = 1;
      #3 chk("t5_reassert", 32'(hold_flag), 32'd1);
      cyc();
      bus_req = 0;
      cyc();

      // T6: reset during FLUSH, then during a bus count
      jmp = 1; jmp_addr = 32'h0000_4000;
      cyc(); jmp = 0; jmp_addr = 0; rst = 1;
      cyc(); rst = 0;
      #3;
      chk("t6_hold", 32'(hold_flag), 32'd0);
      chk("t6_idle", 32'(flush_state), 32'd0);
      cyc();
      bus_req = 1;
      for (int i = 0; i < 5; i++) cyc();
      rst = 1;
      cyc(); rst = 0;
      for (int i = 0; i < 10; i++) begin
         #3 chk("t6_timeout", 32'(bus_timeout), (i == 7) ? 32'd1 : 32'd0);
         cyc();
      end
      idle_inputs();
      cyc();

      // random phase
      streak = 0;
      for (int n = 0; n < 3000; n++) begin
         if (streak == 0) begin
            bus_req = ($urandom_range(0, 2) != 0);
            streak  = $urandom_range(1, 14);
         end
         streak--;
         rst        = ($urandom_range(0, 199) == 0);
         jmp        = ($urandom_range(0, 7) == 0);
         jmp_addr   = $urandom;
         irq        = ($urandom_range(0, 15) == 0);
         irq_addr   = $urandom;
         ex_hold    = ($urandom_range(0, 5) == 0);
         clint_hold = ($urandom_range(0, 11) == 0);
         cyc();
      end
      idle_inputs();
      rst = 0;
      cyc();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
